// File: rtl/ucode_seq.sv
// ucode_seq: multi-cycle microcode sequencer. Accepts one opcode per
// valid/ready handshake, latches W and flags, then drives micro-op strobes
// for one EXEC cycle (MOV/NOP/illegal/single-byte ALU), BYTES EXEC cycles
// (multibyte ALU) or one EXEC plus one FLUSH bubble (JUMP).
module ucode_seq #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned BYTES  = 2,
    localparam int unsigned BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [7:0]        opcode,
    input  logic [DATA_W-1:0] w,
    input  logic              carry,
    input  logic              zero,
    output logic              uop_valid,
    output logic              uop_last,
    output logic [BIDX_W-1:0] byte_index,
    output logic              alu_operation,
    output logic              alu_multibyte_result,
    output logic              jump_operation,
    output logic              jump_condition,
    output logic              mov_operation,
    output logic              destination_w,
    output logic              destination_flags,
    output logic              destination_memory,
    output logic              destination_registers,
    output logic              destination_ports,
    output logic              illegal
);

    localparam logic [1:0] CLS_MOV  = 2'b00;
    localparam logic [1:0] CLS_ALU  = 2'b01;
    localparam logic [1:0] CLS_JUMP = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [BIDX_W-1:0]   cnt, cnt_next;
    logic [7:2]          op_q;
    logic [DATA_W-1:0]   w_q;
    logic                carry_q, zero_q;

    logic                accept;
    logic                is_illegal, multibyte_run, last_byte, exec_last;
    logic                cond_sel;

    assign accept        = (state == IDLE) && op_valid;
    assign is_illegal    = (op_q[7:6] == CLS_MOV || op_q[7:6] == CLS_ALU) && (op_q[4:2] > 3'd4);
    assign multibyte_run = (op_q[7:6] == CLS_ALU) && op_q[5] && !is_illegal;
    assign last_byte     = (cnt == BIDX_W'(BYTES - 1));
    assign exec_last     = !multibyte_run || last_byte;

    // Jump condition select from the latched flags and W, before inversion.
    always_comb begin
        cond_sel = 1'b1;
        case (op_q[5:4])
            2'b00:   cond_sel = 1'b1;
            2'b01:   cond_sel = carry_q;
            2'b10:   cond_sel = zero_q;
            default: cond_sel = (w_q == '0);
        endcase
    end

    // State register and byte counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Opcode, W and flag capture on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            w_q     <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (accept) begin
            op_q    <= opcode[7:2];
            w_q     <= w;
            carry_q <= carry;
            zero_q  <= zero;
        end
    end

    // Next-state logic and micro-op strobe decode.
    always_comb begin
        state_next            = state;
        cnt_next              = cnt;
        op_ready              = 1'b0;
        uop_valid             = 1'b0;
        uop_last              = 1'b0;
        byte_index            = '0;
        alu_operation         = 1'b0;
        alu_multibyte_result  = 1'b0;
        jump_operation        = 1'b0;
        jump_condition        = 1'b0;
        mov_operation         = 1'b0;
        destination_w         = 1'b0;
        destination_flags     = 1'b0;
        destination_memory    = 1'b0;
        destination_registers = 1'b0;
        destination_ports     = 1'b0;
        illegal               = 1'b0;

        case (state)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    state_next = EXEC;
                    cnt_next   = '0;
                end
            end
            EXEC: begin
                uop_valid = 1'b1;
                uop_last  = exec_last;
                illegal   = is_illegal;
                if (multibyte_run) begin
                    byte_index = cnt;
                end
                if (!is_illegal) begin
                    case (op_q[7:6])
                        CLS_MOV:  mov_operation = 1'b1;
                        CLS_ALU: begin
                            alu_operation        = 1'b1;
                            alu_multibyte_result = op_q[5];
                        end
                        CLS_JUMP: begin
                            jump_operation = 1'b1;
                            jump_condition = cond_sel ^ op_q[3];
                        end
                        default: ;
                    endcase
                    if (op_q[7:6] == CLS_MOV || op_q[7:6] == CLS_ALU) begin
                        case (op_q[4:2])
                            3'd0:    destination_w         = 1'b1;
                            3'd1:    destination_flags     = 1'b1;
                            3'd2:    destination_memory    = 1'b1;
                            3'd3:    destination_registers = 1'b1;
                            default: destination_ports     = 1'b1;
                        endcase
                    end
                end
                if (exec_last) begin
                    state_next = (op_q[7:6] == CLS_JUMP && !is_illegal) ? FLUSH : IDLE;
                end else begin
                    cnt_next = cnt + BIDX_W'(1);
                end
            end
            FLUSH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ucode_seq.sv
// tb_ucode_seq: directed plus randomized opcode stream against a per-cycle
// expected-output model derived from the opcode field rules.
module tb_ucode_seq;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned BYTES  = 4;
    localparam int unsigned BIDX_W = 2;
    localparam logic [15:0] IDLE_VEC = 16'h8000;

    logic              clk = 1'b0;
    logic              rst;
    logic              op_valid;
    logic              op_ready;
    logic [7:0]        opcode;
    logic [DATA_W-1:0] w;
    logic              carry, zero;
    logic              uop_valid, uop_last;
    logic [BIDX_W-1:0] byte_index;
    logic              alu_operation, alu_multibyte_result, jump_operation, jump_condition, mov_operation;
    logic              destination_w, destination_flags, destination_memory, destination_registers, destination_ports;
    logic              illegal;

    int tests  = 0;
    int errors = 0;

    ucode_seq #(.DATA_W(DATA_W), .BYTES(BYTES)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .w(w), .carry(carry), .zero(zero),
        .uop_valid(uop_valid), .uop_last(uop_last), .byte_index(byte_index),
        .alu_operation(alu_operation), .alu_multibyte_result(alu_multibyte_result),
        .jump_operation(jump_operation), .jump_condition(jump_condition),
        .mov_operation(mov_operation), .destination_w(destination_w),
        .destination_flags(destination_flags), .destination_memory(destination_memory),
        .destination_registers(destination_registers), .destination_ports(destination_ports),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [15:0] vec;
    assign vec = {op_ready, uop_valid, uop_last, byte_index, alu_operation, alu_multibyte_result,
                  jump_operation, jump_condition, mov_operation, destination_w, destination_flags,
                  destination_memory, destination_registers, destination_ports, illegal};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit op_illegal(input logic [7:0] op);
        int cls = int'(op[7:6]);
        int dst = int'(op[4:2]);
        return (cls < 2) && (dst > 4);
    endfunction

    function automatic int exec_cycles(input logic [7:0] op);
        if (op_illegal(op)) return 1;
        if (op[7:6] == 2'b01 && op[5]) return BYTES;
        return 1;
    endfunction

    function automatic int total_cycles(input logic [7:0] op);
        return exec_cycles(op) + ((op[7:6] == 2'b10) ? 1 : 0);
    endfunction

    // Expected outputs for the k-th cycle after the accept edge.
    function automatic logic [15:0] exp_vec(input logic [7:0] op, input logic [7:0] wv,
                                            input bit c, input bit z, input int k);
        logic [15:0] v = '0;
        int  n   = exec_cycles(op);
        int  cls = int'(op[7:6]);
        int  dst = int'(op[4:2]);
        bit  ill = op_illegal(op);
        bit  cond;
        if (k >= n) return '0;
        v[14] = 1'b1;
        v[13] = (k == n - 1);
        if (ill) begin
            v[0] = 1'b1;
            return v;
        end
        if (cls == 1 && op[5]) v[12:11] = 2'(k);
        if (cls == 1) begin
            v[10] = 1'b1;
            v[9]  = op[5];
        end
        if (cls == 2) begin
            case (int'(op[5:4]))
                0:       cond = 1'b1;
                1:       cond = c;
                2:       cond = z;
                default: cond = (wv == 8'd0);
            endcase
            v[8] = 1'b1;
            v[7] = cond ^ op[3];
        end
        if (cls == 0) v[6] = 1'b1;
        if (cls < 2) v[5 - dst] = 1'b1;
        return v;
    endfunction

    // Present one op at a negedge, then scramble inputs after accept and check each cycle.
    task automatic run_op(input logic [7:0] op, input logic [7:0] wv, input bit c, input bit z);
        int n = total_cycles(op);
        op_valid = 1'b1;
        opcode   = op;
        w        = wv;
        carry    = c;
        zero     = z;
        check($sformatf("ready_%02h", op), vec, IDLE_VEC);
        @(negedge clk);
        op_valid = 1'b0;
        opcode   = 8'($urandom);
        w        = ~wv;
        carry    = ~c;
        zero     = ~z;
        for (int k = 0; k < n; k++) begin
            check($sformatf("op%02h_c%0d", op, k), vec, exp_vec(op, wv, c, z, k));
            @(negedge clk);
        end
    endtask

    initial begin
        rst      = 1'b1;
        op_valid = 1'b1;
        opcode   = 8'h10;
        w        = '0;
        carry    = 1'b0;
        zero     = 1'b0;
        // handshake held during reset must not start an op
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_idle", vec, IDLE_VEC);
        end
        rst = 1'b0;

        run_op(8'h10, 8'h55, 1'b0, 1'b0);
        run_op(8'h60, 8'h12, 1'b0, 1'b0);
        run_op(8'h90, 8'h12, 1'b1, 1'b0);
        run_op(8'h98, 8'h12, 1'b1, 1'b0);
        run_op(8'hB0, 8'h00, 1'b0, 1'b0);
        run_op(8'hB8, 8'h00, 1'b0, 1'b1);
        run_op(8'hA0, 8'h33, 1'b0, 1'b1);
        run_op(8'h74, 8'h00, 1'b1, 1'b1);
        run_op(8'h54, 8'h00, 1'b0, 1'b0);
        run_op(8'hC0, 8'hFF, 1'b1, 1'b1);
        run_op(8'h4C, 8'h01, 1'b0, 1'b0);
        run_op(8'h1C, 8'h01, 1'b0, 1'b0);

        // reset in the middle of a multibyte op
        op_valid = 1'b1;
        opcode   = 8'h60;
        @(negedge clk);
        op_valid = 1'b0;
        check("mid_b0", vec, exp_vec(8'h60, 8'h00, 1'b0, 1'b0, 0));
        @(negedge clk);
        check("mid_b1", vec, exp_vec(8'h60, 8'h00, 1'b0, 1'b0, 1));
        #1 rst = 1'b1;
        #1 check("mid_rst_async", vec, IDLE_VEC);
        @(negedge clk);
        check("mid_rst_hold", vec, IDLE_VEC);
        rst = 1'b0;
        run_op(8'h10, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            logic [7:0] rop;
            logic [7:0] rw;
            rop = 8'($urandom);
            rw  = (($urandom % 4) == 0) ? 8'h00 : 8'($urandom);
            run_op(rop, rw, 1'($urandom), 1'($urandom));
        end
        check("final_idle", vec, IDLE_VEC);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
